// File: rtl/axi4_mem_tester.sv
// AXI4 memory tester: writes NUM_BURSTS 8-beat bursts of {~A,A}, then reads them back.
// Counts responses and data that differ from the pattern, and keeps the address of the first one.
module axi4_mem_tester #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          NUM_BURSTS = 16,
  parameter logic [3:0]  AXI_ID     = 4'h0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_cnt,
  output logic [31:0] first_err_addr,
  output logic        io_axi4_awvalid,
  output logic [3:0]  io_axi4_awid,
  output logic [31:0] io_axi4_awaddr,
  output logic [7:0]  io_axi4_awlen,
  output logic [2:0]  io_axi4_awsize,
  output logic [1:0]  io_axi4_awburst,
  input  logic        io_axi4_awready,
  output logic        io_axi4_wvalid,
  output logic [63:0] io_axi4_wdata,
  output logic [7:0]  io_axi4_wstrb,
  output logic        io_axi4_wlast,
  input  logic        io_axi4_wready,
  output logic        io_axi4_bready,
  input  logic        io_axi4_bvalid,
  input  logic [3:0]  io_axi4_bid,
  input  logic [1:0]  io_axi4_bresp,
  output logic        io_axi4_arvalid,
  output logic [3:0]  io_axi4_arid,
  output logic [31:0] io_axi4_araddr,
  output logic [7:0]  io_axi4_arlen,
  output logic [2:0]  io_axi4_arsize,
  output logic [1:0]  io_axi4_arburst,
  input  logic        io_axi4_arready,
  output logic        io_axi4_rready,
  input  logic        io_axi4_rvalid,
  input  logic [3:0]  io_axi4_rid,
  input  logic [63:0] io_axi4_rdata,
  input  logic [1:0]  io_axi4_rresp,
  input  logic        io_axi4_rlast
);

  typedef enum logic [2:0] {
    IDLE, WADDR, WDATA, WRESP, RADDR, RDATA, DONE
  } state_t;

  localparam logic [16:0] LP_NB = 17'(NUM_BURSTS);

  state_t      r_state;
  state_t      w_nxt;
  logic [15:0] r_k;
  logic [2:0]  r_beat;
  logic [15:0] r_err_cnt;
  logic [31:0] r_first_err;

  logic        w_start;
  logic        w_aw_hs;
  logic        w_w_hs;
  logic        w_b_hs;
  logic        w_ar_hs;
  logic        w_r_hs;
  logic        w_last_beat;
  logic        w_k_last;
  logic [31:0] w_burst_addr;
  logic [31:0] w_beat_addr;
  logic [63:0] w_pattern;
  logic        w_b_bad;
  logic        w_r_bad;
  logic        w_err;
  logic [31:0] w_err_addr;

  assign w_start = start &&
    (r_state == IDLE || r_state == DONE);

  assign w_aw_hs = (r_state == WADDR) && io_axi4_awready;
  assign w_w_hs  = (r_state == WDATA) && io_axi4_wready;
  assign w_b_hs  = (r_state == WRESP) && io_axi4_bvalid;
  assign w_ar_hs = (r_state == RADDR) && io_axi4_arready;
  assign w_r_hs  = (r_state == RDATA) && io_axi4_rvalid;

  assign w_last_beat = (r_beat == 3'd7);
  assign w_k_last = ({1'b0, r_k} + 17'd1) == LP_NB;

  assign w_burst_addr = BASE_ADDR +
    {10'd0, r_k, 6'd0};
  assign w_beat_addr = w_burst_addr +
    {26'd0, r_beat, 3'd0};
  assign w_pattern = {~w_beat_addr, w_beat_addr};

  assign w_b_bad = (io_axi4_bresp != 2'b00) ||
    (io_axi4_bid != AXI_ID);
  assign w_r_bad = (io_axi4_rdata != w_pattern) ||
    (io_axi4_rresp != 2'b00) ||
    (io_axi4_rid != AXI_ID) ||
    (io_axi4_rlast != w_last_beat);

  assign w_err = (w_b_hs && w_b_bad) ||
    (w_r_hs && w_r_bad);
  assign w_err_addr = w_b_hs ? w_burst_addr : w_beat_addr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      IDLE:  if (w_start) w_nxt = WADDR;
      WADDR: if (w_aw_hs) w_nxt = WDATA;
      WDATA: if (w_w_hs && w_last_beat) w_nxt = WRESP;
      WRESP: if (w_b_hs) w_nxt = w_k_last ? RADDR : WADDR;
      RADDR: if (w_ar_hs) w_nxt = RDATA;
      RDATA: begin
        if (w_r_hs && w_last_beat)
          w_nxt = w_k_last ? DONE : RADDR;
      end
      DONE:  if (w_start) w_nxt = WADDR;
      default: w_nxt = IDLE;
    endcase
  end

  always_comb begin
    io_axi4_awvalid = (r_state == WADDR);
    io_axi4_awaddr  = '0;
    io_axi4_wvalid  = (r_state == WDATA);
    io_axi4_wdata   = '0;
    io_axi4_wlast   = 1'b0;
    io_axi4_bready  = (r_state == WRESP);
    io_axi4_arvalid = (r_state == RADDR);
    io_axi4_araddr  = '0;
    io_axi4_rready  = (r_state == RDATA);
    if (io_axi4_awvalid) io_axi4_awaddr = w_burst_addr;
    if (io_axi4_arvalid) io_axi4_araddr = w_burst_addr;
    if (io_axi4_wvalid) begin
      io_axi4_wdata = w_pattern;
      io_axi4_wlast = w_last_beat;
    end
    busy = (r_state != IDLE) && (r_state != DONE);
    done = (r_state == DONE);
    pass = done && (r_err_cnt == 16'd0);
  end

  assign io_axi4_awid    = AXI_ID;
  assign io_axi4_awlen   = 8'd7;
  assign io_axi4_awsize  = 3'd3;
  assign io_axi4_awburst = 2'b01;
  assign io_axi4_wstrb   = 8'hFF;
  assign io_axi4_arid    = AXI_ID;
  assign io_axi4_arlen   = 8'd7;
  assign io_axi4_arsize  = 3'd3;
  assign io_axi4_arburst = 2'b01;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_k         <= '0;
      r_beat      <= '0;
      r_err_cnt   <= '0;
      r_first_err <= '0;
    end else if (w_start) begin
      r_k         <= '0;
      r_beat      <= '0;
      r_err_cnt   <= '0;
      r_first_err <= '0;
    end else begin
      if (w_err) begin
        if (r_err_cnt != 16'hFFFF)
          r_err_cnt <= r_err_cnt + 16'd1;
        if (r_err_cnt == 16'd0)
          r_first_err <= w_err_addr;
      end
      // beat counter wraps 7 -> 0 at the end of every burst
      if (w_w_hs || w_r_hs)
        r_beat <= r_beat + 3'd1;
      if (w_b_hs || (w_r_hs && w_last_beat))
        r_k <= w_k_last ? 16'd0 : r_k + 16'd1;
    end
  end

  assign err_cnt        = r_err_cnt;
  assign first_err_addr = r_first_err;

endmodule

// File: tb/tb_axi4_mem_tester.sv
// Directed bench for axi4_mem_tester: AXI4 slave memory model with
// stall and fault knobs, checked by immediate assertions.
module tb_axi4_mem_tester;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic        busy, done, pass;
  logic [15:0] err_cnt;
  logic [31:0] first_err_addr;
  logic        awvalid, awready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        wvalid, wready, wlast;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        bready, bvalid;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        arvalid, arready;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rready, rvalid, rlast;
  logic [3:0]  rid;
  logic [63:0] rdata;
  logic [1:0]  rresp;

  always #5 clk = ~clk;

  axi4_mem_tester #(
    .BASE_ADDR (32'h0),
    .NUM_BURSTS(2),
    .AXI_ID    (4'h0)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start),
    .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .first_err_addr(first_err_addr),
    .io_axi4_awvalid(awvalid), .io_axi4_awid(awid),
    .io_axi4_awaddr(awaddr), .io_axi4_awlen(awlen),
    .io_axi4_awsize(awsize), .io_axi4_awburst(awburst),
    .io_axi4_awready(awready),
    .io_axi4_wvalid(wvalid), .io_axi4_wdata(wdata),
    .io_axi4_wstrb(wstrb), .io_axi4_wlast(wlast),
    .io_axi4_wready(wready),
    .io_axi4_bready(bready), .io_axi4_bvalid(bvalid),
    .io_axi4_bid(bid), .io_axi4_bresp(bresp),
    .io_axi4_arvalid(arvalid), .io_axi4_arid(arid),
    .io_axi4_araddr(araddr), .io_axi4_arlen(arlen),
    .io_axi4_arsize(arsize), .io_axi4_arburst(arburst),
    .io_axi4_arready(arready),
    .io_axi4_rready(rready), .io_axi4_rvalid(rvalid),
    .io_axi4_rid(rid), .io_axi4_rdata(rdata),
    .io_axi4_rresp(rresp), .io_axi4_rlast(rlast)
  );

  // knobs written by the stimulus only
  int   run_id = 0;
  int   aw_delay = 0;
  logic wr_toggle = 1'b0;
  logic flip_en = 1'b0;
  logic nolast_en = 1'b0;
  int   bresp_err_burst = -1;

  // model state written by the slave process only
  logic [63:0] mem [logic [31:0]];
  logic [31:0] aw_log [0:7];
  logic [31:0] ar_log [0:7];
  logic [31:0] aw_hold, cur_waddr, r_addr, wa, ra;
  logic [63:0] w_hold, first_wdata;
  int seen_run, n_aw, n_ar, w_beats, w_beat;
  int aw_cnt, aw_stalls, b_idx, rd_burst, r_beat;
  int wdata_err, wlast_err, stab_err;
  logic aw_stall, w_stall, b_pend, r_act;

  task automatic clr();
    n_aw = 0; n_ar = 0; w_beats = 0; w_beat = 0;
    aw_cnt = 0; aw_stalls = 0; b_idx = 0;
    rd_burst = 0; r_beat = 0; wdata_err = 0;
    wlast_err = 0; stab_err = 0; aw_stall = 0;
    w_stall = 0; b_pend = 0; r_act = 0;
    first_wdata = '0;
  endtask

  // inputs set here are sampled by the DUT on the next posedge,
  // so every handshake is decided at this negedge
  always @(negedge clk) begin
    bid = 4'h0; rid = 4'h0; rresp = 2'b00;
    if (!rstn) begin
      awready = 0; wready = 0; bvalid = 0; bresp = 0;
      arready = 0; rvalid = 0; rlast = 0; rdata = '0;
      clr();
      seen_run = run_id;
    end else begin
      if (run_id != seen_run) begin
        clr();
        seen_run = run_id;
      end
      if (b_pend) begin
        bvalid = 1'b1;
        bresp = (b_idx == bresp_err_burst) ? 2'b10 : 2'b00;
        if (bready) begin b_pend = 0; b_idx++; end
      end else begin
        bvalid = 1'b0; bresp = 2'b00;
      end
      if (awvalid) begin
        awready = (aw_cnt >= aw_delay);
        if (aw_stall && awaddr != aw_hold) stab_err++;
        if (awready) begin
          if (n_aw < 8) aw_log[n_aw] = awaddr;
          n_aw++; aw_cnt = 0; aw_stall = 0;
          cur_waddr = awaddr; w_beat = 0;
        end else begin
          aw_cnt++; aw_stalls++;
          aw_stall = 1; aw_hold = awaddr;
        end
      end else awready = 1'b0;
      wready = wr_toggle ? ~wready : 1'b1;
      if (wvalid) begin
        if (w_stall && wdata != w_hold) stab_err++;
        if (wready) begin
          wa = cur_waddr + 32'(w_beat * 8);
          if (wdata != {~wa, wa}) wdata_err++;
          if (wlast != (w_beat == 7)) wlast_err++;
          if (w_beats == 0) first_wdata = wdata;
          mem[wa] = wdata;
          w_beats++; w_beat++; w_stall = 0;
          if (w_beat == 8) begin b_pend = 1; w_beat = 0; end
        end else begin
          w_stall = 1; w_hold = wdata;
        end
      end
      if (r_act) begin
        ra = r_addr + 32'(r_beat * 8);
        rvalid = 1'b1;
        rdata = mem.exists(ra) ? mem[ra] : 64'd0;
        if (flip_en && rd_burst == 1 && r_beat == 3)
          rdata[0] = ~rdata[0];
        rlast = (r_beat == 7) &&
          !(nolast_en && rd_burst == 1);
        if (rready) begin
          r_beat++;
          if (r_beat == 8) begin
            r_act = 0; r_beat = 0; rd_burst++;
          end
        end
      end else begin
        rvalid = 0; rlast = 0; rdata = '0;
      end
      arready = 1'b1;
      if (arvalid) begin
        if (n_ar < 8) ar_log[n_ar] = araddr;
        n_ar++; r_addr = araddr; r_act = 1;
      end
    end
  end

  int vec = 0;
  int miss = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic run();
    run_id++;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 400) begin tick(); n++; end
    chk(tag, 64'(done), 64'd1);
  endtask

  initial begin
    rstn = 1'b0;
    start = 1'b0;
    repeat (3) tick();
    chk("rst_status", {busy, done, pass}, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_first_err", first_err_addr, 0);
    chk("rst_valids",
        {awvalid, wvalid, bready, arvalid, rready}, 0);
    rstn = 1'b1;
    tick();
    chk("idle_busy", busy, 0);

    run();
    chk("t1_busy", busy, 1);
    wait_done("t1_done");
    chk("t1_n_aw", n_aw, 2);
    chk("t1_aw0", aw_log[0], 32'h0);
    chk("t1_aw1", aw_log[1], 32'h40);
    chk("t1_wdata0", first_wdata, 64'hFFFFFFFF_00000000);
    chk("t1_w_beats", w_beats, 16);
    chk("t1_wdata_err", wdata_err, 0);
    chk("t1_wlast_err", wlast_err, 0);
    chk("t1_ar1", ar_log[1], 32'h40);
    chk("t1_status", {busy, done, pass}, 3'b011);
    chk("t1_err_cnt", err_cnt, 0);
    chk("t1_ctl", {awlen, awsize, awburst, wstrb},
        {8'd7, 3'd3, 2'b01, 8'hFF});

    flip_en = 1'b1;
    run();
    wait_done("t2_done");
    chk("t2_err_cnt", err_cnt, 1);
    chk("t2_first_err", first_err_addr, 32'h58);
    chk("t2_pass", pass, 0);

    flip_en = 1'b0;
    aw_delay = 5;
    wr_toggle = 1'b1;
    run();
    wait_done("t3_done");
    chk("t3_aw_stalls", aw_stalls, 10);
    chk("t3_stab_err", stab_err, 0);
    chk("t3_w_beats", w_beats, 16);
    chk("t3_wlast_err", wlast_err, 0);
    chk("t3_wdata_err", wdata_err, 0);
    chk("t3_pass", pass, 1);

    aw_delay = 0;
    wr_toggle = 1'b0;
    bresp_err_burst = 0;
    nolast_en = 1'b1;
    run();
    wait_done("t4_done");
    chk("t4_err_cnt", err_cnt, 2);
    chk("t4_first_err", first_err_addr, 32'h0);
    chk("t4_pass", pass, 0);

    bresp_err_burst = -1;
    nolast_en = 1'b0;
    run();
    begin
      int n = 0;
      while (!wvalid && n < 50) begin tick(); n++; end
    end
    chk("t5_in_wdata", wvalid, 1);
    rstn = 1'b0;
    #1;
    chk("t5_rst_ctl",
        {awvalid, wvalid, wlast, bready, arvalid,
         rready, busy, done, pass}, 0);
    chk("t5_rst_err", {err_cnt, first_err_addr}, 0);
    chk("t5_rst_wdata", wdata, 0);
    chk("t5_rst_addr", {awaddr, araddr}, 0);
    repeat (2) tick();
    rstn = 1'b1;
    tick();
    run();
    repeat (3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("t5_done");
    chk("t5_n_aw", n_aw, 2);
    chk("t5_aw0", aw_log[0], 32'h0);
    chk("t5_w_beats", w_beats, 16);
    chk("t5_pass", pass, 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vec, miss);
    $finish;
  end

endmodule
